inst_encoder: RTL

Streaming RV32I instruction encoder: accepts decoded instruction fields (kind, register indices, funct3/funct7, immediate) over a valid/ready handshake and emits packed 32-bit instruction words, each tagged with an instruction-memory word address. It is the inverse of the core's instruction decoder. It sits between the test/program generator and the instruction-memory write port, so programs can be built from field-level descriptions. Illegal field combinations are dropped and flagged, never emitted.

---
 rtl/inst_encoder_if.sv | 37 +++
 rtl/inst_encoder.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/inst_encoder_if.sv
`default_nettype none
//==============================================================================
// Module   : inst_encoder_if
// Purpose  : Field-level instruction input stream and encoded-word output stream
// Revision : 1.0 - initial release
//==============================================================================
interface inst_encoder_if #(
    parameter int ADDR_W = 10
);
    logic              in_valid;
    logic              in_ready;
    logic [3:0]        in_kind;
    logic [4:0]        in_rd;
    logic [4:0]        in_rs1;
    logic [4:0]        in_rs2;
    logic [2:0]        in_funct3;
    logic [6:0]        in_funct7;
    logic [31:0]       in_imm;
    logic              in_last;
    logic              out_valid;
    logic              out_ready;
    logic [31:0]       out_inst;
    logic [ADDR_W-1:0] out_addr;

    modport master (
        output in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
               in_imm, in_last, out_ready,
        input  in_ready, out_valid, out_inst, out_addr
    );

    modport slave (
        input  in_valid, in_kind, in_rd, in_rs1, in_rs2, in_funct3, in_funct7,
               in_imm, in_last, out_ready,
        output in_ready, out_valid, out_inst, out_addr
    );
endinterface
`default_nettype wire

// File: rtl/inst_encoder.sv
`default_nettype none
//==============================================================================
// Module   : inst_encoder
// Purpose  : Two-stage RV32I field-to-word encoder with address tagging
// Revision : 1.0 - initial release
//==============================================================================
module inst_encoder #(
    parameter int ADDR_W    = 10,
    parameter int BASE_ADDR = 0
) (
    input  wire             clk,
    input  wire             rst_n,
    input  wire             clear,
    inst_encoder_if.slave   bus,
    output logic [ADDR_W:0] count,
    output logic            done,
    output logic            err_kind,
    output logic            err_imm
);
    localparam logic [6:0]        c_OP_ARITH  = 7'b0110011;
    localparam logic [6:0]        c_OP_ARIMM  = 7'b0010011;
    localparam logic [6:0]        c_OP_LOAD   = 7'b0000011;
    localparam logic [6:0]        c_OP_STORE  = 7'b0100011;
    localparam logic [6:0]        c_OP_BRANCH = 7'b1100011;
    localparam logic [6:0]        c_OP_JAL    = 7'b1101111;
    localparam logic [6:0]        c_OP_JALR   = 7'b1100111;
    localparam logic [6:0]        c_OP_LUI    = 7'b0110111;
    localparam logic [6:0]        c_OP_AUIPC  = 7'b0010111;
    localparam logic [ADDR_W-1:0] c_BASE      = ADDR_W'(BASE_ADDR);
    localparam logic [ADDR_W-1:0] c_ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   c_COUNT_ONE = (ADDR_W+1)'(1);
    localparam logic [ADDR_W:0]   c_COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};

    logic              r_live;
    logic              r_s1_valid;
    logic [3:0]        r_s1_kind;
    logic [4:0]        r_s1_rd;
    logic [4:0]        r_s1_rs1;
    logic [4:0]        r_s1_rs2;
    logic [2:0]        r_s1_f3;
    logic [6:0]        r_s1_f7;
    logic [31:0]       r_s1_imm;
    logic              r_s1_last;
    logic              r_s2_valid;
    logic [31:0]       r_s2_inst;
    logic [ADDR_W-1:0] r_s2_addr;
    logic              r_s2_last;
    logic [ADDR_W-1:0] r_next_addr;
    logic [ADDR_W:0]   r_count;
    logic              r_done;
    logic              r_err_kind;
    logic              r_err_imm;

    logic              w_s2_open;
    logic              w_s1_adv;
    logic              w_accept;
    logic              w_s2_load;
    logic              w_s1_drop;
    logic              w_out_fire;
    logic              w_s1_legal;
    logic              w_fits_i;
    logic              w_fits_b;
    logic              w_fits_j;
    logic              w_is_shift;
    logic              w_bad_kind;
    logic              w_bad_imm;
    logic [31:0]       w_inst;

    assign w_s2_open  = !r_s2_valid || bus.out_ready;
    assign w_s1_adv   = !r_s1_valid || w_s2_open;
    assign w_accept   = bus.in_valid && bus.in_ready;
    assign w_s1_legal = !w_bad_kind && !w_bad_imm;
    assign w_s2_load  = r_s1_valid && w_s2_open && w_s1_legal;
    assign w_s1_drop  = r_s1_valid && w_s2_open && !w_s1_legal;
    assign w_out_fire = r_s2_valid && bus.out_ready;

    assign bus.in_ready  = r_live && w_s1_adv && !r_done && !clear;
    assign bus.out_valid = r_s2_valid;
    assign bus.out_inst  = r_s2_inst;
    assign bus.out_addr  = r_s2_addr;
    assign count         = r_count;
    assign done          = r_done;
    assign err_kind      = r_err_kind;
    assign err_imm       = r_err_imm;

    // Signed range checks: the bits above the field's sign bit must all equal it.
    assign w_fits_i   = (&r_s1_imm[31:11]) || !(|r_s1_imm[31:11]);
    assign w_fits_b   = ((&r_s1_imm[31:12]) || !(|r_s1_imm[31:12])) && !r_s1_imm[0];
    assign w_fits_j   = ((&r_s1_imm[31:20]) || !(|r_s1_imm[31:20])) && !r_s1_imm[0];
    assign w_is_shift = (r_s1_f3 == 3'b001) || (r_s1_f3 == 3'b101);

    always_comb begin
        w_inst     = '0;
        w_bad_kind = 1'b0;
        w_bad_imm  = 1'b0;
        case (r_s1_kind)
            4'd0: w_inst = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, c_OP_ARITH};
            4'd1: begin
                if (w_is_shift) begin
                    w_inst    = {r_s1_f7, r_s1_imm[4:0], r_s1_rs1, r_s1_f3, r_s1_rd, c_OP_ARIMM};
                    w_bad_imm = |r_s1_imm[31:5];
                end else begin
                    w_inst    = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, c_OP_ARIMM};
                    w_bad_imm = !w_fits_i;
                end
            end
            4'd2: begin
                w_inst    = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, c_OP_LOAD};
                w_bad_imm = !w_fits_i;
            end
            4'd3: begin
                w_inst    = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_imm[4:0], c_OP_STORE};
                w_bad_imm = !w_fits_i;
            end
            4'd4: begin
                w_inst    = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                             r_s1_imm[4:1], r_s1_imm[11], c_OP_BRANCH};
                w_bad_imm = !w_fits_b;
            end
            4'd5: begin
                w_inst    = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                             r_s1_rd, c_OP_JAL};
                w_bad_imm = !w_fits_j;
            end
            4'd6: begin
                w_inst    = {r_s1_imm[11:0], r_s1_rs1, 3'b000, r_s1_rd, c_OP_JALR};
                w_bad_imm = !w_fits_i;
            end
            4'd7: begin
                w_inst    = {r_s1_imm[31:12], r_s1_rd, c_OP_LUI};
                w_bad_imm = |r_s1_imm[11:0];
            end
            4'd8: begin
                w_inst    = {r_s1_imm[31:12], r_s1_rd, c_OP_AUIPC};
                w_bad_imm = |r_s1_imm[11:0];
            end
            default: w_bad_kind = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_live      <= 1'b0;
            r_s1_valid  <= 1'b0;
            r_s1_kind   <= '0;
            r_s1_rd     <= '0;
            r_s1_rs1    <= '0;
            r_s1_rs2    <= '0;
            r_s1_f3     <= '0;
            r_s1_f7     <= '0;
            r_s1_imm    <= '0;
            r_s1_last   <= 1'b0;
            r_s2_valid  <= 1'b0;
            r_s2_inst   <= '0;
            r_s2_addr   <= c_BASE;
            r_s2_last   <= 1'b0;
            r_next_addr <= c_BASE;
            r_count     <= '0;
            r_done      <= 1'b0;
            r_err_kind  <= 1'b0;
            r_err_imm   <= 1'b0;
        end else begin
            r_live <= 1'b1;
            if (clear) begin
                r_s1_valid  <= 1'b0;
                r_s2_valid  <= 1'b0;
                r_s2_inst   <= '0;
                r_s2_addr   <= c_BASE;
                r_s2_last   <= 1'b0;
                r_next_addr <= c_BASE;
                r_count     <= '0;
                r_done      <= 1'b0;
                r_err_kind  <= 1'b0;
                r_err_imm   <= 1'b0;
            end else begin
                if (w_s1_adv) begin
                    r_s1_valid <= w_accept;
                end
                if (w_accept) begin
                    r_s1_kind <= bus.in_kind;
                    r_s1_rd   <= bus.in_rd;
                    r_s1_rs1  <= bus.in_rs1;
                    r_s1_rs2  <= bus.in_rs2;
                    r_s1_f3   <= bus.in_funct3;
                    r_s1_f7   <= bus.in_funct7;
                    r_s1_imm  <= bus.in_imm;
                    r_s1_last <= bus.in_last;
                end
                if (w_s2_load) begin
                    r_s2_valid  <= 1'b1;
                    r_s2_inst   <= w_inst;
                    r_s2_addr   <= r_next_addr;
                    r_s2_last   <= r_s1_last;
                    r_next_addr <= r_next_addr + c_ADDR_ONE;
                end else if (w_out_fire) begin
                    r_s2_valid <= 1'b0;
                end
                if (w_out_fire && (r_count != c_COUNT_MAX)) begin
                    r_count <= r_count + c_COUNT_ONE;
                end
                if ((w_out_fire && r_s2_last) || (w_s1_drop && r_s1_last)) begin
                    r_done <= 1'b1;
                end
                if (r_s1_valid && w_bad_kind) begin
                    r_err_kind <= 1'b1;
                end
                if (r_s1_valid && w_bad_imm) begin
                    r_err_imm <= 1'b1;
                end
            end
        end
    end
endmodule
`default_nettype wire
